// File: rtl/if_fetch_stage.sv
//==============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, fetches one word per
//               instruction over a request/grant bus and drives the IF/ID
//               pipeline register consumed by decode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_fetch_stage #(
    parameter logic [29:0] RESET_VECTOR = 30'h0,
    parameter logic [31:0] NOP_INSN     = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [29:0] bus_addr,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [29:0] r_pc;
    logic [31:0] r_buf;
    logic        r_as_n;
    logic [29:0] r_addr;
    logic [29:0] r_if_pc;
    logic [31:0] r_if_insn;
    logic        r_if_en;

    state_t      w_state_nxt;
    logic [29:0] w_pc_nxt;
    logic [31:0] w_buf_nxt;
    logic        w_as_n_nxt;
    logic [29:0] w_addr_nxt;
    logic [29:0] w_if_pc_nxt;
    logic [31:0] w_if_insn_nxt;
    logic        w_if_en_nxt;

    logic        w_redirect;
    logic [29:0] w_target;
    logic        w_done;

    // flush outranks stall; a decode branch only counts when decode is moving
    assign w_redirect = flush | (br_taken & ~stall);
    assign w_target   = flush ? new_pc : br_addr;
    assign w_done     = ~bus_rdy_;

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_buf_nxt     = r_buf;
        w_as_n_nxt    = r_as_n;
        w_addr_nxt    = r_addr;
        w_if_pc_nxt   = r_if_pc;
        w_if_insn_nxt = r_if_insn;
        w_if_en_nxt   = r_if_en;

        case (r_state)
            S_REQ: begin
                if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_if_en_nxt   = 1'b0;
                    w_if_insn_nxt = NOP_INSN;
                end else begin
                    if (!stall) begin
                        w_if_en_nxt   = 1'b0;
                        w_if_insn_nxt = NOP_INSN;
                    end
                    if (!bus_grnt_) begin
                        w_state_nxt = S_ACC;
                        w_addr_nxt  = r_pc;
                        w_as_n_nxt  = 1'b0;
                    end
                end
            end

            S_ACC: begin
                if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_if_en_nxt   = 1'b0;
                    w_if_insn_nxt = NOP_INSN;
                    // an unfinished transfer must still run to completion
                    if (w_done) begin
                        w_as_n_nxt  = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_DROP;
                    end
                end else if (stall) begin
                    if (w_done) begin
                        w_buf_nxt   = bus_rd_data;
                        w_as_n_nxt  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_done) begin
                    w_if_pc_nxt   = r_pc;
                    w_if_insn_nxt = bus_rd_data;
                    w_if_en_nxt   = 1'b1;
                    w_pc_nxt      = r_pc + 30'd1;
                    w_as_n_nxt    = 1'b1;
                    w_state_nxt   = S_REQ;
                end else begin
                    w_if_en_nxt   = 1'b0;
                    w_if_insn_nxt = NOP_INSN;
                end
            end

            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_if_en_nxt   = 1'b0;
                    w_if_insn_nxt = NOP_INSN;
                    w_state_nxt   = S_REQ;
                end else if (!stall) begin
                    w_if_pc_nxt   = r_pc;
                    w_if_insn_nxt = r_buf;
                    w_if_en_nxt   = 1'b1;
                    w_pc_nxt      = r_pc + 30'd1;
                    w_state_nxt   = S_REQ;
                end
            end

            S_DROP: begin
                if (w_redirect) begin
                    w_pc_nxt      = w_target;
                    w_if_en_nxt   = 1'b0;
                    w_if_insn_nxt = NOP_INSN;
                end
                if (w_done) begin
                    w_as_n_nxt  = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_VECTOR;
            r_buf     <= NOP_INSN;
            r_as_n    <= 1'b1;
            r_addr    <= 30'd0;
            r_if_pc   <= RESET_VECTOR;
            r_if_insn <= NOP_INSN;
            r_if_en   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_buf     <= w_buf_nxt;
            r_as_n    <= w_as_n_nxt;
            r_addr    <= w_addr_nxt;
            r_if_pc   <= w_if_pc_nxt;
            r_if_insn <= w_if_insn_nxt;
            r_if_en   <= w_if_en_nxt;
        end
    end

    assign bus_req_ = (r_state == S_HOLD);
    assign bus_as_  = r_as_n;
    assign bus_rw   = 1'b1;
    assign bus_addr = r_addr;
    assign if_pc    = r_if_pc;
    assign if_insn  = r_if_insn;
    assign if_en    = r_if_en;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
//==============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage with a memory slave and
//               an IF/ID scoreboard driven by the redirect/stall rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_fetch_stage;

    localparam logic [29:0] C_RV  = 30'h0;
    localparam logic [31:0] C_NOP = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] new_pc = 30'd0;
    logic        br_taken = 1'b0;
    logic [29:0] br_addr = 30'd0;
    logic        bus_grnt_ = 1'b1;
    logic [31:0] bus_rd_data = 32'd0;
    logic        bus_rdy_ = 1'b1;
    logic        bus_req_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;
    int wait_mode = 0;   // 0: zero wait, 1: three wait cycles, 2: random 0..3
    int grant_mode = 0;  // 0: grant tied active, 1: random grant
    int cnt = 0;

    // values seen by the design at the most recent rising edge
    logic        p_rst = 1'b0, p_stall = 1'b0, p_flush = 1'b0, p_br = 1'b0;
    logic        p_as = 1'b1, p_rdy = 1'b1;
    logic [29:0] p_new = 30'd0, p_bra = 30'd0, p_addr = 30'd0;

    if_fetch_stage #(.RESET_VECTOR(C_RV), .NOP_INSN(C_NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_),
        .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
        .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b00, a} + 32'h100;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        p_rst   <= reset;
        p_stall <= stall;
        p_flush <= flush;
        p_br    <= br_taken;
        p_new   <= new_pc;
        p_bra   <= br_addr;
        p_as    <= bus_as_;
        p_rdy   <= bus_rdy_;
        p_addr  <= bus_addr;
    end

    // scoreboard monitor followed by the memory slave, both on the falling edge
    initial begin
        logic [29:0] q[$];
        logic [29:0] e_pc;
        logic [31:0] e_insn;
        logic        e_en;
        logic [29:0] nxt;
        e_pc = C_RV; e_insn = C_NOP; e_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                q.delete();
                q.push_back(C_RV);
                e_pc = C_RV; e_insn = C_NOP; e_en = 1'b0;
            end else if (p_rst) begin
                chk("bus_rw", {31'd0, bus_rw}, 32'd1);
                if (!p_as && p_rdy) begin
                    chk("as_held", {31'd0, bus_as_}, 32'd0);
                    chk("addr_held", {2'b00, bus_addr}, {2'b00, p_addr});
                end
                if (!p_as && !p_rdy)
                    chk("as_release", {31'd0, bus_as_}, 32'd1);
                if (p_flush || (p_br && !p_stall)) begin
                    q.delete();
                    q.push_back(p_flush ? p_new : p_bra);
                    e_en = 1'b0; e_insn = C_NOP;
                end else if (!p_stall) begin
                    if (if_en === 1'b1 && q.size() != 0) begin
                        nxt = q.pop_front();
                        e_pc = nxt; e_insn = mem_word(nxt); e_en = 1'b1;
                        q.push_back(nxt + 30'd1);
                        n_deliv++;
                    end else begin
                        e_en = 1'b0; e_insn = C_NOP;
                    end
                end
                chk("if_en", {31'd0, if_en}, {31'd0, e_en});
                chk("if_pc", {2'b00, if_pc}, {2'b00, e_pc});
                chk("if_insn", if_insn, e_insn);
            end
            if (bus_as_ !== 1'b0) begin
                case (wait_mode)
                    0:       cnt = 0;
                    1:       cnt = 3;
                    default: cnt = $urandom_range(0, 3);
                endcase
                bus_rdy_ = 1'b1;
            end else if (cnt == 0) begin
                bus_rdy_ = 1'b0;
                bus_rd_data = mem_word(bus_addr);
            end else begin
                bus_rdy_ = 1'b1;
                cnt--;
            end
            bus_grnt_ = (grant_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_as(input logic v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_as_ === v) begin ok = 1'b1; break; end
        end
        chk("wait_as_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_en();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_en === 1'b1) begin ok = 1'b1; break; end
        end
        chk("wait_en_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_flush(input logic [29:0] tgt);
        @(negedge clk); #1; flush = 1'b1; new_pc = tgt;
        @(negedge clk); #1; flush = 1'b0;
    endtask

    initial begin
        int n;
        int n0;
        logic [31:0] r;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        logic [31:0] r;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_if_en", {31'd0, if_en}, 32'd0);
        chk("rst_if_insn", if_insn, C_NOP);
        chk("rst_if_pc", {2'b00, if_pc}, {2'b00, C_RV});
        chk("rst_bus_as", {31'd0, bus_as_}, 32'd1);
        chk("rst_bus_addr", {2'b00, bus_addr}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req_}, 32'd0);
        #1 reset = 1'b1;

        // zero-wait bus: one instruction every other cycle
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("zw_en", {31'd0, if_en}, (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                chk("zw_pc", {2'b00, if_pc}, k / 2 - 1);
                chk("zw_insn", if_insn, mem_word(30'(k / 2 - 1)));
            end
        end

        // three wait states: strobe held low for four cycles
        #1 wait_mode = 1;
        wait_as(1'b1);
        wait_as(1'b0);
        n = 0;
        while (bus_as_ === 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("wait3_strobe_cycles", n, 32'd4);

        // stall arriving with the read data
        wait_as(1'b0);
        repeat (3) @(negedge clk);
        #1 stall = 1'b1;
        repeat (4) @(negedge clk);
        #1 stall = 1'b0;

        // flush while a slow access is outstanding
        wait_as(1'b0);
        pulse_flush(30'h40);
        wait_en();
        chk("flush_target_pc", {2'b00, if_pc}, 32'h40);
        chk("flush_target_insn", if_insn, mem_word(30'h40));

        // branch ignored while stalled, taken once stall drops
        @(negedge clk); #1; stall = 1'b1; br_taken = 1'b1; br_addr = 30'h20;
        repeat (3) @(negedge clk);
        #1 stall = 1'b0;
        @(negedge clk); #1; br_taken = 1'b0;
        wait_en();
        chk("branch_target_pc", {2'b00, if_pc}, 32'h20);

        // PC wrap at the top of the address space
        wait_mode = 0;
        pulse_flush(30'h3FFFFFFF);
        wait_en();
        chk("wrap_pc", {2'b00, if_pc}, 32'h3FFFFFFF);
        wait_as(1'b0);
        chk("wrap_bus_addr", {2'b00, bus_addr}, 32'd0);

        // randomized traffic
        wait_mode = 2; grant_mode = 1;
        n0 = n_deliv;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            br_taken = ($urandom_range(0, 7) == 0);
            r = $urandom; new_pc  = r[29:0];
            r = $urandom; br_addr = r[29:0];
        end
        @(negedge clk); #1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        repeat (10) @(negedge clk);
        chk("random_progress", {31'd0, 1'((n_deliv - n0) >= 100)}, 32'd1);

        // reset in the middle of a transfer
        wait_mode = 1; grant_mode = 0;
        wait_as(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_bus_as", {31'd0, bus_as_}, 32'd1);
        chk("midrst_if_en", {31'd0, if_en}, 32'd0);
        chk("midrst_if_pc", {2'b00, if_pc}, {2'b00, C_RV});
        chk("midrst_if_insn", if_insn, C_NOP);
        @(negedge clk); #1; reset = 1'b1;
        wait_en();
        chk("post_rst_pc", {2'b00, if_pc}, {2'b00, C_RV});
        chk("post_rst_insn", if_insn, mem_word(C_RV));

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
